// File: rtl/nco_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nco_pkg : shared widths, quadrant encoding and LUT amplitude for the NCO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package nco_pkg;

   localparam int  c_ACC_WIDTH    = 32;
   localparam int  c_PHASE_WIDTH  = 12;
   localparam int  c_DITHER_WIDTH = 5;
   localparam int  c_OUT_WIDTH    = 12;
   localparam real c_PI           = 3.14159265358979323846;

   typedef enum logic [1:0] {
      QUAD_I   = 2'd0,
      QUAD_II  = 2'd1,
      QUAD_III = 2'd2,
      QUAD_IV  = 2'd3
   } quad_e;

   // Quadrants II and IV walk the quarter-wave table backwards.
   function automatic logic quad_mirrored(input quad_e q);
      return (q == QUAD_II) || (q == QUAD_IV);
   endfunction

   function automatic logic quad_negative(input quad_e q);
      return (q == QUAD_III) || (q == QUAD_IV);
   endfunction

   function automatic int lut_amp(input int out_width);
      return (1 << (out_width - 1)) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nco_sine_qlut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nco_sine_qlut : quarter-wave sine magnitude ROM with registered read     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nco_sine_qlut
   import nco_pkg::*;
#(
   parameter int ADDR_WIDTH = c_PHASE_WIDTH - 2,
   parameter int MAG_WIDTH  = c_OUT_WIDTH - 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [MAG_WIDTH-1:0]  o_mag
);

   localparam int c_DEPTH = 1 << ADDR_WIDTH;
   localparam int c_AMP   = lut_amp(MAG_WIDTH + 1);

   logic [MAG_WIDTH-1:0] w_rom [c_DEPTH];
   logic [MAG_WIDTH-1:0] r_mag;

   // Half-LSB offset keeps every entry strictly positive and symmetric about pi/4.
   for (genvar k = 0; k < c_DEPTH; k++) begin : g_lut
      localparam real c_ANG = c_PI / 2.0 * (real'(k) + 0.5) / real'(c_DEPTH);
      localparam int  c_VAL = $rtoi(real'(c_AMP) * $sin(c_ANG) + 0.5);
      assign w_rom[k] = MAG_WIDTH'(c_VAL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mag <= '0;
      end else begin
         r_mag <= w_rom[i_addr];
      end
   end

   assign o_mag = r_mag;

endmodule
`default_nettype wire

// File: rtl/nco_phase_dither_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nco_phase_dither_core : FCW accumulator, phase dither, sine LUT pipeline |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nco_phase_dither_core
   import nco_pkg::*;
#(
   parameter int ACC_WIDTH      = c_ACC_WIDTH,
   parameter int PHASE_WIDTH    = c_PHASE_WIDTH,
   parameter int DITHER_WIDTH   = c_DITHER_WIDTH,
   parameter int OUT_WIDTH      = c_OUT_WIDTH,
   parameter int DITHER_EN      = 1,
   parameter int UPDATE_ON_WRAP = 0
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        sync,
   input  logic [ACC_WIDTH-1:0]        fcw_in,
   input  logic                        fcw_valid,
   output logic                        fcw_ready,
   input  logic [DITHER_WIDTH-1:0]     dither_in,
   output logic signed [OUT_WIDTH-1:0] sample,
   output logic                        out_valid
);

   localparam int c_TW = PHASE_WIDTH + DITHER_WIDTH;
   localparam int c_AW = PHASE_WIDTH - 2;
   localparam int c_MW = OUT_WIDTH - 1;

   logic [ACC_WIDTH-1:0]        r_acc;
   logic [ACC_WIDTH-1:0]        r_fcw_active;
   logic [ACC_WIDTH-1:0]        r_fcw_shadow;
   logic                        r_pending;
   logic                        r_v1;
   logic [PHASE_WIDTH-1:0]      r_phase;
   logic                        r_v2;
   quad_e                       r_quad3;
   logic                        r_v3;
   logic signed [OUT_WIDTH-1:0] r_sample;
   logic                        r_out_valid;

   logic [ACC_WIDTH:0]          w_sum;
   logic                        w_xfer;
   logic                        w_apply;
   logic [DITHER_WIDTH-1:0]     w_dither;
   logic [c_TW-1:0]             w_t;
   quad_e                       w_quad;
   logic [c_AW-1:0]             w_a;
   logic [c_AW-1:0]             w_addr;
   logic [c_MW-1:0]             w_mag;
   logic signed [OUT_WIDTH-1:0] w_mag_s;

   assign w_sum     = {1'b0, r_acc} + {1'b0, r_fcw_active};
   assign w_xfer    = fcw_valid & ~r_pending;
   assign fcw_ready = ~r_pending;

   // In wrap mode the swap lands on the add that overflows, keeping phase continuous.
   always_comb begin
      w_apply = r_pending;
      if (UPDATE_ON_WRAP != 0) begin
         w_apply = r_pending & (sync | (en & w_sum[ACC_WIDTH]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fcw_active <= '0;
         r_fcw_shadow <= '0;
         r_pending    <= 1'b0;
      end else begin
         if (w_apply) begin
            r_fcw_active <= r_fcw_shadow;
            r_pending    <= 1'b0;
         end
         if (w_xfer) begin
            r_fcw_shadow <= fcw_in;
            r_pending    <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_v1  <= 1'b0;
      end else begin
         r_v1 <= en | sync;
         if (sync) begin
            r_acc <= '0;
         end else if (en) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
         end
      end
   end

   // Dither lands below the truncation point; the sum wraps at 2*pi.
   assign w_dither = (DITHER_EN != 0) ? dither_in : '0;
   assign w_t      = r_acc[ACC_WIDTH-1 -: c_TW] + {{PHASE_WIDTH{1'b0}}, w_dither};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
         r_v2    <= 1'b0;
      end else begin
         r_phase <= PHASE_WIDTH'(w_t >> DITHER_WIDTH);
         r_v2    <= r_v1;
      end
   end

   assign w_quad = quad_e'(r_phase[PHASE_WIDTH-1 -: 2]);
   assign w_a    = r_phase[c_AW-1:0];
   assign w_addr = quad_mirrored(w_quad) ? ~w_a : w_a;

   nco_sine_qlut #(
      .ADDR_WIDTH (c_AW),
      .MAG_WIDTH  (c_MW)
   ) u_qlut (
      .clk    (clk),
      .rst    (rst),
      .i_addr (w_addr),
      .o_mag  (w_mag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_quad3 <= QUAD_I;
         r_v3    <= 1'b0;
      end else begin
         r_quad3 <= w_quad;
         r_v3    <= r_v2;
      end
   end

   assign w_mag_s = $signed({1'b0, w_mag});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sample    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_v3;
         if (r_v3) begin
            r_sample <= quad_negative(r_quad3) ? -w_mag_s : w_mag_s;
         end
      end
   end

   assign sample    = r_sample;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_dither_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nco_phase_dither_core : immediate-update and wrap-update instances    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nco_phase_dither_core;

   logic              clk = 1'b0;
   logic              rst, en, sync, fcw_valid;
   logic [31:0]       fcw_in;
   logic [4:0]        dither;
   logic [1:0]        ready, ov;
   logic signed [11:0] s0, s1;

   always #5 clk = ~clk;

   nco_phase_dither_core #(.UPDATE_ON_WRAP(0)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .fcw_in(fcw_in),
      .fcw_valid(fcw_valid), .fcw_ready(ready[0]), .dither_in(dither),
      .sample(s0), .out_valid(ov[0]));

   nco_phase_dither_core #(.UPDATE_ON_WRAP(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .fcw_in(fcw_in),
      .fcw_valid(fcw_valid), .fcw_ready(ready[1]), .dither_in(dither),
      .sample(s1), .out_valid(ov[1]));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit started = 0;

   // Reference state: architectural registers plus per-edge input history.
   logic [31:0] m_acc [2];
   logic [31:0] m_act [2];
   logic [31:0] m_sh  [2];
   bit          m_pend[2];
   logic [31:0] h_acc [2][8];
   bit          h_stim[8];
   bit          h_rst [8];
   int          h_dith[8];
   bit          exp_ov [2];
   bit          exp_rdy[2];
   int          exp_smp[2];

   function automatic int sine_of(input int p);
      int  quad, a, k, m;
      real v;
      quad = p / 1024;
      a    = p % 1024;
      k    = (quad % 2 == 1) ? 1023 - a : a;
      v    = 2047.0 * $sin(3.14159265358979323846 * 0.5 * (real'(k) + 0.5) / 1024.0);
      m    = $rtoi(v + 0.5);
      return (quad >= 2) ? -m : m;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step_model();
      int           i, p;
      logic [32:0]  s;
      bit           xfer, apply, valid;
      i = cyc % 8;
      h_rst[i]  = rst;
      h_stim[i] = !rst && (en || sync);
      h_dith[i] = int'(dither);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_acc[d] = 0; m_act[d] = 0; m_sh[d] = 0; m_pend[d] = 0;
         end else begin
            s     = {1'b0, m_acc[d]} + {1'b0, m_act[d]};
            xfer  = fcw_valid && !m_pend[d];
            apply = (d == 0) ? m_pend[d] : (m_pend[d] && (sync || (en && s[32])));
            if (sync)    m_acc[d] = 0;
            else if (en) m_acc[d] = s[31:0];
            if (apply) begin m_act[d] = m_sh[d]; m_pend[d] = 0; end
            if (xfer)  begin m_sh[d] = fcw_in;   m_pend[d] = 1; end
         end
         h_acc[d][i] = m_acc[d];
         exp_rdy[d]  = !m_pend[d];
         valid = 0;
         if (cyc >= 3) begin
            valid = h_stim[(cyc - 3) % 8];
            for (int j = 0; j < 4; j++) if (h_rst[(cyc - j) % 8]) valid = 0;
         end
         exp_ov[d] = valid;
         if (rst) exp_smp[d] = 0;
         else if (valid) begin
            p = (int'(h_acc[d][(cyc - 3) % 8] >> 15) + h_dith[(cyc - 2) % 8]) % 131072;
            exp_smp[d] = sine_of(p / 32);
         end
      end
      cyc++;
      started = 1;
   endtask

   initial forever begin
      @(posedge clk);
      step_model();
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         check("valid0", int'(ov[0]),    int'(exp_ov[0]));
         check("sample0", int'(s0),      exp_smp[0]);
         check("ready0", int'(ready[0]), int'(exp_rdy[0]));
         check("valid1", int'(ov[1]),    int'(exp_ov[1]));
         check("sample1", int'(s1),      exp_smp[1]);
         check("ready1", int'(ready[1]), int'(exp_rdy[1]));
      end
   end

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1; en = 0; sync = 0; fcw_valid = 0;
      nxt();
      rst = 0;
   endtask

   task automatic dither_probe(input logic [4:0] dv, input int exp_s);
      reset_dut();
      dither = dv; fcw_in = 32'h000F_8000; fcw_valid = 1;
      nxt();
      fcw_valid = 0;
      nxt();
      en = 1;
      nxt();
      en = 0;
      repeat (3) nxt();
      check("lit_dither_sample", int'(s0), exp_s);
      check("lit_dither_valid", int'(ov[0]), 1);
   endtask

   int seq [4];

   initial begin
      seq[0] = 2; seq[1] = 2047; seq[2] = -2; seq[3] = -2047;
      rst = 1; en = 0; sync = 0; fcw_valid = 0; fcw_in = 0; dither = 0;
      repeat (3) nxt();
      check("lit_rst_ready", int'(ready[0]), 1);
      check("lit_rst_valid", int'(ov[0]), 0);
      check("lit_rst_sample", int'(s0), 0);
      rst = 0;

      // quarter-turn FCW with maximal dither
      fcw_in = 32'h4000_0000; fcw_valid = 1; dither = 31;
      nxt();
      fcw_valid = 0; en = 1;
      check("lit_ready_after_xfer", int'(ready[0]), 0);
      repeat (4) nxt();
      for (int k = 0; k < 8; k++) begin
         check("lit_quarter_seq", int'(s0), seq[k % 4]);
         nxt();
      end
      sync = 1;
      nxt();
      sync = 0;
      repeat (3) nxt();
      for (int k = 0; k < 4; k++) begin
         check("lit_sync_seq", int'(s0), seq[k]);
         nxt();
      end

      // single en pulse right after reset
      reset_dut();
      en = 1;
      nxt();
      en = 0;
      check("lit_lat_e1", int'(ov[0]), 0);
      nxt();
      check("lit_lat_e2", int'(ov[0]), 0);
      nxt();
      check("lit_lat_e3", int'(ov[0]), 0);
      nxt();
      check("lit_lat_e4", int'(ov[0]), 1);
      check("lit_lat_sample", int'(s0), 2);
      nxt();
      check("lit_lat_e5", int'(ov[0]), 0);

      dither_probe(5'd0, 2);
      dither_probe(5'd1, 5);

      // held offer of two words; wrap-mode instance waits for sync / wrap
      reset_dut();
      fcw_in = 32'h8000_0000; fcw_valid = 1;
      nxt();
      check("lit_hold_ready0_a", int'(ready[0]), 0);
      fcw_in = 32'h1234_5678;
      nxt();
      check("lit_hold_ready0_b", int'(ready[0]), 1);
      nxt();
      fcw_valid = 0;
      check("lit_hold_ready0_c", int'(ready[0]), 0);
      en = 1;
      repeat (4) begin
         nxt();
         check("lit_wrap_pending", int'(ready[1]), 0);
      end
      en = 0; sync = 1;
      nxt();
      sync = 0;
      check("lit_wrap_sync_apply", int'(ready[1]), 1);
      fcw_in = 32'h0000_1000; fcw_valid = 1;
      nxt();
      fcw_valid = 0; en = 1;
      check("lit_wrap_wait0", int'(ready[1]), 0);
      nxt();
      check("lit_wrap_wait1", int'(ready[1]), 0);
      nxt();
      check("lit_wrap_applied", int'(ready[1]), 1);

      // reset with pending words and a full pipe
      repeat (6) nxt();
      fcw_in = 32'h0ABC_DEF0; fcw_valid = 1;
      nxt();
      fcw_valid = 0; rst = 1;
      nxt();
      check("lit_midrst_valid", int'(ov[0]), 0);
      check("lit_midrst_sample", int'(s0), 0);
      check("lit_midrst_ready0", int'(ready[0]), 1);
      check("lit_midrst_ready1", int'(ready[1]), 1);
      rst = 0; en = 0;

      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 9) < 7);
         sync      = ($urandom_range(0, 29) == 0);
         fcw_valid = ($urandom_range(0, 3) == 0);
         fcw_in    = (n < 1000) ? 32'($urandom_range(0, 32'h0010_0000)) : 32'($urandom);
         dither    = 5'($urandom);
         nxt();
      end
      rst = 0; en = 0; sync = 0; fcw_valid = 0;
      repeat (6) nxt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
